// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the current micro-address and computes the next one from the
// microword sequencing field, with memory stall, call/return stack, wait, halt and interrupt entry.
module micro_sequencer #(
    parameter int unsigned UADDR_W     = 5,
    parameter int unsigned NUM_COND    = 4,
    parameter int unsigned STACK_DEPTH = 2,
    parameter int unsigned RESET_ADDR  = 0,
    parameter int unsigned IRQ_ADDR    = 31
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [2:0]                   seq_type,
    input  logic [UADDR_W-1:0]           next_addr,
    input  logic [$clog2(NUM_COND)-1:0]  cond_sel,
    input  logic                         cond_pol,
    input  logic                         mem_req,
    input  logic                         mem_ready,
    input  logic [NUM_COND-1:0]          cond,
    input  logic [UADDR_W-1:0]           ib_target,
    input  logic [UADDR_W-1:0]           sb_target,
    input  logic                         irq,
    input  logic                         irq_en,
    output logic [UADDR_W-1:0]           uaddr,
    output logic                         stall,
    output logic                         ib_boundary,
    output logic                         irq_ack,
    output logic                         halted,
    output logic                         stack_err
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH) + 1;
    localparam logic [UADDR_W-1:0] RST_A = UADDR_W'(RESET_ADDR);
    localparam logic [UADDR_W-1:0] IRQ_A = UADDR_W'(IRQ_ADDR);
    localparam logic [SP_W-1:0]    SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        SEQ_IB   = 3'b000,
        SEQ_SB   = 3'b001,
        SEQ_BC   = 3'b010,
        SEQ_DB   = 3'b011,
        SEQ_CALL = 3'b100,
        SEQ_RET  = 3'b101,
        SEQ_WAIT = 3'b110,
        SEQ_HALT = 3'b111
    } seq_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e                state;
    seq_e                  seq;
    logic [SP_W-1:0]       sp;
    logic [SP_W-1:0]       sp_dec;
    logic [UADDR_W-1:0]    uaddr_inc;
    logic                  taken;
    logic                  irq_take;
    logic                  push_ok;
    logic [UADDR_W-1:0]    stack_mem [STACK_DEPTH];

    assign seq       = seq_e'(seq_type);
    assign stall     = mem_req & ~mem_ready;
    assign taken     = (cond[cond_sel] == cond_pol);
    assign irq_take  = irq & irq_en;
    assign uaddr_inc = uaddr + UADDR_W'(1);
    assign sp_dec    = sp - SP_W'(1);
    assign push_ok   = (sp != SP_FULL);
    assign halted    = (state == ST_HALT);

    // Stack contents need no reset; only the pointer defines validity.
    always_ff @(posedge clock) begin
        if (!stall && state == ST_RUN && seq == SEQ_CALL && push_ok)
            stack_mem[sp[SP_W-2:0]] <= uaddr_inc;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uaddr       <= RST_A;
            sp          <= '0;
            state       <= ST_RUN;
            stack_err   <= 1'b0;
            ib_boundary <= 1'b0;
            irq_ack     <= 1'b0;
        end else begin
            ib_boundary <= 1'b0;
            irq_ack     <= 1'b0;
            if (!stall) begin
                if (state == ST_HALT) begin
                    if (irq_take) begin
                        uaddr   <= IRQ_A;
                        irq_ack <= 1'b1;
                        state   <= ST_RUN;
                    end
                end else begin
                    unique case (seq)
                        SEQ_IB: begin
                            if (irq_take) begin
                                uaddr   <= IRQ_A;
                                irq_ack <= 1'b1;
                            end else begin
                                uaddr       <= ib_target;
                                ib_boundary <= 1'b1;
                            end
                        end
                        SEQ_SB:   uaddr <= sb_target;
                        SEQ_BC:   uaddr <= taken ? next_addr : uaddr_inc;
                        SEQ_DB:   uaddr <= next_addr;
                        SEQ_CALL: begin
                            uaddr <= next_addr;
                            if (push_ok) sp <= sp + SP_W'(1);
                            else         stack_err <= 1'b1;
                        end
                        SEQ_RET: begin
                            if (sp == '0) begin
                                uaddr     <= RST_A;
                                stack_err <= 1'b1;
                            end else begin
                                uaddr <= stack_mem[sp_dec[SP_W-2:0]];
                                sp    <= sp_dec;
                            end
                        end
                        SEQ_WAIT: if (taken) uaddr <= next_addr;
                        SEQ_HALT: state <= ST_HALT;
                        default:  uaddr <= uaddr;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios plus random stimulus, all compared against
// a queue-based behavioural model of the sequencing rules.
module tb_micro_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] seq_type;
    logic [4:0] next_addr;
    logic [1:0] cond_sel;
    logic       cond_pol;
    logic       mem_req;
    logic       mem_ready;
    logic [3:0] cond;
    logic [4:0] ib_target;
    logic [4:0] sb_target;
    logic       irq;
    logic       irq_en;
    logic [4:0] uaddr;
    logic       stall;
    logic       ib_boundary;
    logic       irq_ack;
    logic       halted;
    logic       stack_err;

    micro_sequencer #(
        .UADDR_W(5), .NUM_COND(4), .STACK_DEPTH(2), .RESET_ADDR(0), .IRQ_ADDR(31)
    ) dut (
        .clock(clock), .reset_n(reset_n), .seq_type(seq_type), .next_addr(next_addr),
        .cond_sel(cond_sel), .cond_pol(cond_pol), .mem_req(mem_req), .mem_ready(mem_ready),
        .cond(cond), .ib_target(ib_target), .sb_target(sb_target), .irq(irq), .irq_en(irq_en),
        .uaddr(uaddr), .stall(stall), .ib_boundary(ib_boundary), .irq_ack(irq_ack),
        .halted(halted), .stack_err(stack_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_uaddr;
    int m_stack[$];
    bit m_halted, m_err, m_ib, m_ack;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_uaddr = 0; m_stack.delete(); m_halted = 0; m_err = 0; m_ib = 0; m_ack = 0;
    endfunction

    function automatic void model_step();
        bit tk;
        m_ib = 0; m_ack = 0;
        if (mem_req && !mem_ready) return;
        tk = (cond[cond_sel] == cond_pol);
        if (m_halted) begin
            if (irq && irq_en) begin m_uaddr = 31; m_ack = 1; m_halted = 0; end
            return;
        end
        case (seq_type)
            3'd0: if (irq && irq_en) begin m_uaddr = 31; m_ack = 1; end
                  else begin m_uaddr = ib_target; m_ib = 1; end
            3'd1: m_uaddr = sb_target;
            3'd2: m_uaddr = tk ? int'(next_addr) : (m_uaddr + 1) % 32;
            3'd3: m_uaddr = next_addr;
            3'd4: begin
                if (m_stack.size() == 2) m_err = 1;
                else m_stack.push_back((m_uaddr + 1) % 32);
                m_uaddr = next_addr;
            end
            3'd5: if (m_stack.size() == 0) begin m_uaddr = 0; m_err = 1; end
                  else m_uaddr = m_stack.pop_back();
            3'd6: if (tk) m_uaddr = next_addr;
            default: m_halted = 1;
        endcase
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".uaddr"},  int'(uaddr),       m_uaddr);
        check({tag, ".halted"}, int'(halted),      int'(m_halted));
        check({tag, ".err"},    int'(stack_err),   int'(m_err));
        check({tag, ".ib"},     int'(ib_boundary), int'(m_ib));
        check({tag, ".ack"},    int'(irq_ack),     int'(m_ack));
    endtask

    task automatic cycle(input string tag, input int st, input int na, input int cs, input int cp,
                         input int mr, input int rdy, input int cn, input int ibt, input int sbt,
                         input int iq, input int ie);
        seq_type = 3'(st); next_addr = 5'(na); cond_sel = 2'(cs); cond_pol = 1'(cp);
        mem_req = 1'(mr); mem_ready = 1'(rdy); cond = 4'(cn); ib_target = 5'(ibt);
        sb_target = 5'(sbt); irq = 1'(iq); irq_en = 1'(ie);
        #1;
        check({tag, ".stall"}, int'(stall), int'(mem_req && !mem_ready));
        model_step();
        @(posedge clock);
        #1;
        check_state(tag);
    endtask

    task automatic randomize_inputs();
        seq_type = 3'($urandom); next_addr = 5'($urandom); cond_sel = 2'($urandom);
        cond_pol = 1'($urandom); mem_req = 1'($urandom); mem_ready = 1'($urandom);
        cond = 4'($urandom); ib_target = 5'($urandom); sb_target = 5'($urandom);
        irq = 1'($urandom); irq_en = 1'($urandom);
    endtask

    // Short asynchronous reset pulse between clock edges; outputs must clear immediately.
    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #2;
        model_reset();
        check_state(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        randomize_inputs();
        model_reset();
        repeat (3) begin
            @(posedge clock);
            randomize_inputs();
        end
        #1;
        check_state("reset");
        reset_n = 1'b1;

        // Dispatch chain
        cycle("ib",  0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0);
        cycle("sb",  1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        cycle("db",  3, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Conditional branch with wrap
        cycle("db31",  3, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("bc_nt", 2, 20, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("bc_tk", 2, 20, 0, 1, 0, 0, 1, 0, 0, 0, 0);

        // Memory stall then release
        repeat (4) cycle("stall", 3, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle("stall_rel", 3, 9, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        // Call / return, overflow, underflow
        cycle("db5",   3, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("call1", 4, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("call2", 4, 24, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("ret1",  5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("ret2",  5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle("call_ovf", 4, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle("ret_unf", 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Wait on condition N (bit 1) going low
        cycle("wait_hold", 6, 7, 1, 0, 0, 0, 4'b0010, 0, 0, 0, 0);
        cycle("wait_go",   6, 7, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);

        // Halt and interrupt exit
        cycle("halt", 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle("halt_noen", 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("halt_irq", 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("post_irq", 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle("irq_stall", 0, 0, 0, 0, 1, 0, 0, 6, 0, 1, 1);
        cycle("irq_rel", 0, 0, 0, 0, 1, 1, 0, 6, 0, 1, 1);
        cycle("after", 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);

        // Reset mid-call
        cycle("pre_rst", 4, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        async_reset("rst_mid");

        // Random phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
            cycle("rnd", $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised next-generation microprogram sequencer for the multi-cycle CPU control path.
- Holds the current micro-state address and drives it to an external control store.
- Takes back the microword's sequencing fields and computes the next state. Sources: IB (decode dispatch), SB (addressing-mode dispatch), BC (conditional branch) and DB (direct branch).
- New in this generation: memory-handshake stall, micro-subroutine call/return stack, wait-on-condition, halt, and interrupt entry at instruction boundaries.

Parameters:
UADDR_W, 5, micro-address width
NUM_COND, 4, number of condition inputs (Z, N, C, V by default)
STACK_DEPTH, 2, micro-return-stack entries (power of 2, >=2)
RESET_ADDR, 0, micro-address loaded on reset (fetch state)
IRQ_ADDR, 31, micro-address entered on accepted interrupt

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
seq_type  in  3  microword sequencing field: 000 IB, 001 SB, 010 BC, 011 DB, 100 CALL, 101 RET, 110 WAIT, 111 HALT
next_addr  in  UADDR_W  microword target address
cond_sel  in  $clog2(NUM_COND)  condition select for BC/WAIT
cond_pol  in  1  1 = branch on condition true, 0 = on false
mem_req  in  1  current microword issues a memory access
mem_ready  in  1  memory completes the access this cycle
cond  in  NUM_COND  status flags
ib_target  in  UADDR_W  first state of decoded instruction
sb_target  in  UADDR_W  addressing-mode entry state
irq  in  1  level interrupt request
irq_en  in  1  interrupt enable
uaddr  out  UADDR_W  current micro-state address (registered)
stall  out  1  combinational: mem_req & ~mem_ready
ib_boundary  out  1  registered pulse: an IB dispatch took effect last cycle
irq_ack  out  1  registered pulse: interrupt accepted last cycle
halted  out  1  sequencer in HALT
stack_err  out  1  sticky: push on full or pop on empty

Behaviour:
- Reset (async, reset_n=0): uaddr=RESET_ADDR; stack pointer=0 (empty); halted=0; stack_err=0; ib_boundary=0; irq_ack=0. Reset asserted mid-stall or mid-call returns everything to these values; stack contents are don't-care.
- Each rising edge with stall=0 and halted=0 loads uaddr with next value:
  - IB: irq&irq_en -> IRQ_ADDR with irq_ack=1; else ib_target with ib_boundary=1.
  - SB: sb_target.
  - BC: taken = (cond[cond_sel]==cond_pol). Taken -> next_addr; not taken -> uaddr+1, wrapping modulo 2^UADDR_W.
  - DB: next_addr.
  - CALL: push uaddr+1 (wrapping), go to next_addr. If full: no push, go to next_addr, set stack_err.
  - RET: pop into uaddr. If empty: uaddr=RESET_ADDR, set stack_err.
  - WAIT: hold uaddr until taken (BC rule), then go to next_addr. No interrupt check in WAIT.
  - HALT: uaddr unchanged, halted=1.
- Stall: mem_req=1 and mem_ready=0 freezes uaddr, the stack, and all pulses (pulse outputs 0 while stalled). When mem_ready rises, the transition computed from current inputs takes effect on that edge; latency 1 cycle after mem_ready. mem_req with mem_ready=1 in the same cycle causes no stall.
- Halt exit: only via reset, or irq&irq_en. Irq exit goes to IRQ_ADDR with irq_ack=1 and clears halted.
- Simultaneous events:
  - Stall has priority over every transition, including the irq at IB.
  - Interrupt is sampled only at IB or in HALT.
  - CALL and RET never occur in the same cycle (single seq_type).
- Pulse outputs: ib_boundary and irq_ack are high for exactly one cycle per event.
- stack_err: cleared only by reset.
- Width rules: all address arithmetic is UADDR_W bits, unsigned, and wraps.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with random inputs, release -> uaddr=0, halted=0, stack_err=0, no pulses.
- Dispatch chain: seq_type IB with ib_target=8, then SB with sb_target=3, then DB with next_addr=12 -> uaddr 8, 3, 12 on successive edges; ib_boundary high only in the cycle after the IB edge.
- Conditional branch and wrap: uaddr=31, BC, cond_sel=0, cond_pol=1, Z=0 -> uaddr=0. Then Z=1, next_addr=20 -> uaddr=20.
- Memory stall: mem_req=1, mem_ready=0 for 4 cycles under DB next_addr=9 -> uaddr constant and stall=1. mem_ready=1 -> uaddr=9 next edge.
- Call/return: from uaddr=5, CALL next_addr=16; from 16, CALL 24; then RET, RET -> uaddr 16, 24, 17, 6, stack_err=0. Third CALL at depth 2 -> stack_err=1 and stays 1. RET on empty -> uaddr=0.
- Interrupt and halt: enter HALT, assert irq with irq_en=0 -> stays halted. Set irq_en=1 -> uaddr=31, irq_ack pulses once, halted=0. IB with irq&irq_en while stalled -> no accept until mem_ready.
